ysyx_25020047_lsu_hs: RTL and testbench

YSYX_25020047_LSU_HS -- requirements
Module: ysyx_25020047_lsu_hs

---
 rtl/ysyx_25020047_lsu_hs.sv | 216 +++++++++++++++++++++
 tb/tb_ysyx_25020047_lsu_hs.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_lsu_hs.sv
// ysyx_25020047_lsu_hs -- load/store unit bridging a core request/response
// port to a single-beat memory bus. One transaction is in flight at a time.
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   -> misaligned accesses fault without a bus access
//                         undefined -> the byte offset is rounded down to the size
//                                      alignment and the access proceeds
module ysyx_25020047_lsu_hs #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,   // 32 or 64
  parameter int TIMEOUT = 255   // 0 disables the memory timeout
) (
  input  logic                clk,
  input  logic                rst,
  // core request
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  // core response
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  // memory request
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  // memory response
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // request decode
  logic [OFF_W-1:0]    req_off_raw;
  logic [OFF_W-1:0]    size_low;
  logic [OFF_W-1:0]    req_off;
  logic [STRB_W-1:0]   base_mask;
  logic [STRB_W-1:0]   req_mask;
  logic [DATA_W-1:0]   req_wdata_sh;
  logic                req_illegal;
  logic                req_bad;

  // load data extraction
  logic [DATA_W-1:0]   ld_shift;
  logic [DATA_W-1:0]   ld_keep;
  logic                ld_sign;
  logic [DATA_W-1:0]   ld_data;

  // Decode the incoming request: lane offset, byte enables, shifted store data, faults.
  always_comb begin
    req_off_raw = req_addr[OFF_W-1:0];
    case (req_size)
      2'd0:    begin size_low = OFF_W'(0); base_mask = STRB_W'(8'h01); end
      2'd1:    begin size_low = OFF_W'(1); base_mask = STRB_W'(8'h03); end
      2'd2:    begin size_low = OFF_W'(3); base_mask = STRB_W'(8'h0F); end
      default: begin size_low = OFF_W'(7); base_mask = STRB_W'(8'hFF); end
    endcase
    // A doubleword cannot fit on a 32-bit bus.
    req_illegal = (DATA_W == 32) && (req_size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    req_off = req_off_raw;
    req_bad = req_illegal || ((req_off_raw & size_low) != '0);
`else
    req_off = req_off_raw & ~size_low;
    req_bad = req_illegal;
`endif
    req_mask     = base_mask << req_off;
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // Right-align returned load data, truncate to the access size and extend.
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    ld_keep  = '1;
    ld_sign  = 1'b0;
    case (size_q)
      2'd0:    begin ld_keep = DATA_W'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1:    begin ld_keep = DATA_W'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2:    begin ld_keep = DATA_W'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: begin ld_keep = '1;                     ld_sign = 1'b0;         end
    endcase
    ld_data = (ld_shift & ld_keep) | ((signed_q && ld_sign) ? ~ld_keep : '0);
  end

  // Next-state logic: sequence IDLE -> REQ -> WAIT -> RESP, with fault and timeout shortcuts.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = '0;  // cleared on every state change, counts only while lingering
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_off;
          addr_d   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d  = req_wdata_sh;
          wmask_d  = req_mask;
          if (req_bad) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = we_q ? '0 : ld_data;
          err_d   = mem_resp_err;
          state_d = RESP;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      off_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign mem_req_valid = (state_q == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;

endmodule

// File: tb/tb_ysyx_25020047_lsu_hs.sv
// Bench for ysyx_25020047_lsu_hs: a 32-bit instance (default timeout) and a
// 64-bit instance (TIMEOUT=4) share stimulus; sel picks the active one.
// Expected values come from a byte-array reference memory and per-byte rules.
module tb_ysyx_25020047_lsu_hs;

  localparam int TMO32 = 255;
  localparam int TMO64 = 4;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_ready, mem_req_ready, mem_resp_valid, mem_resp_err;
  logic [63:0] mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wmask;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_we;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_wmask;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wmask;

  logic [7:0]  bus_mem [256];
  logic [7:0]  ref_mem [256];

  int          n_cmp;
  int          n_bad;
  logic [31:0] last_maddr;
  logic [7:0]  last_wmask;
  logic [63:0] last_wdata, last_rdata;
  logic        last_err;

  ysyx_25020047_lsu_hs #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO32)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata[31:0]), .mem_resp_err(mem_resp_err)
  );

  ysyx_25020047_lsu_hs #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TMO64)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
  assign o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
  assign o_resp_err      = sel ? b_resp_err      : a_resp_err;
  assign o_resp_rdata    = sel ? b_resp_rdata    : {32'h0, a_resp_rdata};
  assign o_mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
  assign o_mem_we        = sel ? b_mem_we        : a_mem_we;
  assign o_mem_addr      = sel ? b_mem_addr      : a_mem_addr;
  assign o_mem_wdata     = sel ? b_mem_wdata     : {32'h0, a_mem_wdata};
  assign o_mem_wmask     = sel ? b_mem_wmask     : {4'h0, a_mem_wmask};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference view of a request: bus address, byte enables, lane data, fault.
  task automatic model_req(input bit is64, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [63:0] wd, output bit trap, output logic [31:0] e_addr,
                           output logic [7:0] e_mask, output logic [63:0] e_wdata, output int off);
    int nb;
    int bytes;
    nb     = is64 ? 8 : 4;
    bytes  = 1 << sz;
    off    = int'(addr[2:0]) % nb;
    e_addr = addr - 32'(off);
    trap   = !is64 && (sz == 2'd3);
    if (off % bytes != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      trap = 1'b1;
`else
      off = off - (off % bytes);
`endif
    end
    e_mask  = '0;
    e_wdata = '0;
    for (int i = 0; i < nb; i++) begin
      if (i >= off) begin
        if (i < off + bytes) e_mask[i] = 1'b1;
        e_wdata[8*i +: 8] = wd[8*(i-off) +: 8];
      end
    end
  endtask

  function automatic logic [63:0] load_ref(input bit is64, input logic [1:0] sz, input bit sg,
                                           input int idx);
    logic [63:0] v;
    int bytes;
    v     = '0;
    bytes = 1 << sz;
    for (int k = 0; k < bytes; k++) v[8*k +: 8] = ref_mem[(idx + k) % 256];
    if (sg && v[8*bytes-1]) for (int k = bytes; k < 8; k++) v[8*k +: 8] = 8'hFF;
    if (!is64) v[63:32] = '0;
    return v;
  endfunction

  // One complete transaction: core side plus a scripted memory.
  // rsp_dly >= timeout means the memory never answers.
  task automatic txn(input string tag, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [31:0] addr, input logic [63:0] wd, input int rdy_dly,
                     input int rsp_dly, input int rr_dly, input bit merr);
    bit          trap;
    bit          responded;
    logic [31:0] e_addr;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata, e_rdata;
    logic        e_err;
    logic [31:0] h_addr;
    logic [7:0]  h_mask;
    logic [63:0] h_wdata;
    int          off;
    int          tmo;
    int          nb;
    model_req(sel, sz, addr, wd, trap, e_addr, e_mask, e_wdata, off);
    tmo = sel ? TMO64 : TMO32;
    nb  = sel ? 8 : 4;
    e_rdata = '0;
    e_err   = 1'b1;

    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    check({tag, "/req_ready"}, o_req_ready, 1'b1);
    check({tag, "/idle_resp_valid"}, o_resp_valid, 1'b0);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = {$urandom, $urandom};

    if (trap) begin
      check({tag, "/trap_no_bus"}, o_mem_req_valid, 1'b0);
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        mem_req_ready  = (k == rdy_dly);
        mem_resp_valid = 1'($urandom);
        mem_resp_err   = 1'($urandom);
        mem_rdata      = {$urandom, $urandom};
        check({tag, "/mem_req_valid"}, o_mem_req_valid, 1'b1);
        check({tag, "/mem_we"}, o_mem_we, wr);
        check({tag, "/mem_addr"}, o_mem_addr, e_addr);
        check({tag, "/mem_wmask"}, o_mem_wmask, e_mask);
        if (wr) check({tag, "/mem_wdata"}, o_mem_wdata, e_wdata);
        check({tag, "/req_resp_valid"}, o_resp_valid, 1'b0);
        h_addr = o_mem_addr; h_mask = o_mem_wmask; h_wdata = o_mem_wdata;
        tick();
      end
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
      last_maddr = h_addr; last_wmask = h_mask; last_wdata = h_wdata;
      if (wr) begin
        for (int i = 0; i < nb; i++)
          if (h_mask[i]) bus_mem[(int'(h_addr[7:0]) + i) % 256] = h_wdata[8*i +: 8];
        for (int k = 0; k < (1 << sz); k++)
          ref_mem[(int'(e_addr[7:0]) + off + k) % 256] = wd[8*k +: 8];
      end
      responded = 1'b0;
      for (int k = 0; k < tmo; k++) begin
        check({tag, "/wait_resp_valid"}, o_resp_valid, 1'b0);
        check({tag, "/wait_mem_req_valid"}, o_mem_req_valid, 1'b0);
        if (k == rsp_dly) begin
          mem_resp_valid = 1'b1;
          mem_resp_err   = merr;
          for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = bus_mem[(int'(h_addr[7:0]) + i) % 256];
          tick();
          mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_rdata = {$urandom, $urandom};
          responded = 1'b1;
          break;
        end
        tick();
      end
      if (responded) begin
        e_err   = merr;
        e_rdata = wr ? 64'h0 : load_ref(sel, sz, sg, int'(e_addr[7:0]) + off);
      end
    end

    for (int k = 0; k <= rr_dly; k++) begin
      resp_ready     = (k == rr_dly);
      mem_resp_valid = 1'($urandom);
      mem_resp_err   = 1'($urandom);
      mem_rdata      = {$urandom, $urandom};
      check({tag, "/resp_valid"}, o_resp_valid, 1'b1);
      check({tag, "/resp_rdata"}, o_resp_rdata, e_rdata);
      check({tag, "/resp_err"}, o_resp_err, e_err);
      check({tag, "/resp_req_ready"}, o_req_ready, 1'b0);
      last_rdata = o_resp_rdata; last_err = o_resp_err;
      tick();
    end
    resp_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    check({tag, "/done_resp_valid"}, o_resp_valid, 1'b0);
    check({tag, "/done_req_ready"}, o_req_ready, 1'b1);
  endtask

  task automatic idle_check(input string tag, input int n, input bit stray);
    for (int k = 0; k < n; k++) begin
      mem_resp_valid = stray && (k == 0);
      mem_resp_err   = stray;
      check({tag, "/idle_resp_valid"}, o_resp_valid, 1'b0);
      check({tag, "/idle_req_ready"}, o_req_ready, 1'b1);
      check({tag, "/idle_mem_req_valid"}, o_mem_req_valid, 1'b0);
      tick();
    end
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "/req_ready"}, o_req_ready, 1'b1);
    check({tag, "/resp_valid"}, o_resp_valid, 1'b0);
    check({tag, "/resp_rdata"}, o_resp_rdata, 64'h0);
    check({tag, "/resp_err"}, o_resp_err, 1'b0);
    check({tag, "/mem_req_valid"}, o_mem_req_valid, 1'b0);
    check({tag, "/mem_we"}, o_mem_we, 1'b0);
    check({tag, "/mem_addr"}, o_mem_addr, 32'h0);
    check({tag, "/mem_wdata"}, o_mem_wdata, 64'h0);
    check({tag, "/mem_wmask"}, o_mem_wmask, 8'h0);
  endtask

  task automatic random_txns(input string tag, input int n);
    logic [1:0] sz;
    int         rsp_max;
    rsp_max = sel ? TMO64 : 5;
    for (int i = 0; i < n; i++) begin
      sz = sel ? 2'($urandom) : 2'($urandom_range(0, 3));
      txn(tag, 1'($urandom), sz, 1'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 255)),
          {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, rsp_max),
          $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) idle_check(tag, 1, 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    sel = 1'b0; rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    mem_rdata = '0;
    last_maddr = '0; last_wmask = '0; last_wdata = '0; last_rdata = '0; last_err = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end

    // Reset state of both instances.
    tick();
    reset_outputs("rst32");
    sel = 1'b1;
    #1;
    reset_outputs("rst64");
    sel = 1'b0;
    tick();
    rst = 1'b0;
    idle_check("post_rst", 2, 1'b1);

    // Byte store at the top lane, then signed byte load.
    txn("sb", 1'b1, 2'd0, 1'b0, 32'h8000_0003, 64'hAB, 0, 0, 0, 1'b0);
    check("sb/wmask", last_wmask, 8'h08);
    check("sb/wdata", last_wdata, 64'hAB00_0000);
    txn("lb", 1'b0, 2'd0, 1'b1, 32'h8000_0003, 64'h0, 0, 0, 0, 1'b0);
    check("lb/rdata", last_rdata, 64'hFFFF_FFAB);

    // Half store at offset 2, then unsigned half load.
    txn("sh", 1'b1, 2'd1, 1'b0, 32'h8000_0002, 64'h1234, 0, 0, 0, 1'b0);
    check("sh/wmask", last_wmask, 8'h0C);
    check("sh/wdata", last_wdata, 64'h1234_0000);
    txn("lhu", 1'b0, 2'd1, 1'b0, 32'h8000_0002, 64'h0, 0, 0, 0, 1'b0);
    check("lhu/rdata", last_rdata, 64'h0000_1234);

    // Slow memory grant and slow core: everything held stable, one response.
    txn("stall", 1'b1, 2'd2, 1'b0, 32'h8000_0020, 64'hDEAD_BEEF, 5, 2, 3, 1'b1);
    check("stall/err", last_err, 1'b1);
    idle_check("stall", 3, 1'b0);

    // Misaligned word load.
    txn("lw_mis", 1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'h0, 0, 1, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis/err", last_err, 1'b1);
    check("lw_mis/rdata", last_rdata, 64'h0);
`else
    check("lw_mis/addr", last_maddr, 32'h8000_0000);
    check("lw_mis/err", last_err, 1'b0);
`endif

    // Doubleword on the 32-bit bus faults without a bus access.
    txn("ld32", 1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'h0, 0, 0, 1, 1'b0);
    check("ld32/err", last_err, 1'b1);

    // Reset while waiting for memory abandons the transaction.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h8000_0040;
    tick();
    req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rst_wait/in_wait", o_resp_valid, 1'b0);
    rst = 1'b1;
    #1;
    reset_outputs("rst_wait");
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    rst = 1'b0;
    idle_check("rst_wait", 2, 1'b0);
    txn("after_rst", 1'b0, 2'd2, 1'b1, 32'h8000_0020, 64'h0, 0, 0, 0, 1'b0);
    check("after_rst/rdata", last_rdata, 64'hDEAD_BEEF);

    random_txns("rand32", 40);

    // 64-bit instance.
    sel = 1'b1;
    #1;
    txn("sd", 1'b1, 2'd3, 1'b0, 32'h8000_0008, 64'h0123_4567_89AB_CDEF, 1, 0, 0, 1'b0);
    check("sd/wmask", last_wmask, 8'hFF);
    txn("ld", 1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'h0, 0, 2, 1, 1'b0);
    check("ld/rdata", last_rdata, 64'h0123_4567_89AB_CDEF);
    txn("lw64", 1'b0, 2'd2, 1'b1, 32'h8000_000C, 64'h0, 0, 0, 0, 1'b0);
    check("lw64/rdata", last_rdata, 64'h0000_0000_0123_4567);

    // Memory never answers: timeout fault, late response ignored, next one normal.
    txn("tmo", 1'b0, 2'd2, 1'b0, 32'h8000_0010, 64'h0, 0, 100, 2, 1'b0);
    check("tmo/err", last_err, 1'b1);
    idle_check("tmo_late", 2, 1'b1);
    txn("tmo_next", 1'b0, 2'd3, 1'b0, 32'h8000_0008, 64'h0, 0, 3, 0, 1'b0);
    check("tmo_next/err", last_err, 1'b0);
    check("tmo_next/rdata", last_rdata, 64'h0123_4567_89AB_CDEF);

    random_txns("rand64", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
